sync_handshake_fifo: RTL and testbench

SYNC_HANDSHAKE_FIFO -- requirements
Module: sync_handshake_fifo

---
 rtl/cdc_fifo_pkg.sv | 16 +
 rtl/sync_handshake_fifo_stats.sv | 58 +++++
 rtl/sync_handshake_fifo.sv | 120 ++++++++++++
 tb/tb_sync_handshake_fifo.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cdc_fifo_pkg.sv
// Shared constants and width helpers for the synchronous handshake FIFO.
package cdc_fifo_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32'd32;
    localparam int unsigned DEFAULT_DEPTH      = 32'd8;

    // One extra pointer bit distinguishes full from empty when the index bits match.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int unsigned level_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_handshake_fifo_stats.sv
// Overflow sticky flag and high-water mark for the handshake FIFO.
module sync_handshake_fifo_stats
    import cdc_fifo_pkg::*;
#(
    parameter int unsigned depth = DEFAULT_DEPTH
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic                            stats_clr_i,
    input  logic                            wr_i,
    input  logic                            wr_ready_i,
    input  logic [level_width(depth)-1:0]   level_i,
    input  logic [level_width(depth)-1:0]   level_next_i,
    output logic                            overflow_o,
    output logic [level_width(depth)-1:0]   max_level_o
);

    localparam int unsigned LW = level_width(depth);

    logic          overflow_q, overflow_d;
    logic [LW-1:0] max_level_q, max_level_d;

    // Clear wins over set; a clear re-seeds the high-water mark from the present level.
    always_comb begin
        overflow_d  = overflow_q;
        max_level_d = max_level_q;
        if (stats_clr_i) begin
            overflow_d  = 1'b0;
            max_level_d = level_i;
        end else begin
            if (wr_i && !wr_ready_i) begin
                overflow_d = 1'b1;
            end else begin
                overflow_d = overflow_q;
            end
            if (level_next_i > max_level_q) begin
                max_level_d = level_next_i;
            end else begin
                max_level_d = max_level_q;
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            overflow_q  <= 1'b0;
            max_level_q <= {LW{1'b0}};
        end else begin
            overflow_q  <= overflow_d;
            max_level_q <= max_level_d;
        end
    end

    assign overflow_o  = overflow_q;
    assign max_level_o = max_level_q;

endmodule

// File: rtl/sync_handshake_fifo.sv
// First-word-fall-through synchronous FIFO with valid/ready handshakes.
// Optional statistics (overflow, max_level) enabled by SYNC_HANDSHAKE_FIFO_STATS_EN.
module sync_handshake_fifo
    import cdc_fifo_pkg::*;
#(
    parameter int unsigned data_width        = DEFAULT_DATA_WIDTH,
    parameter int unsigned depth             = DEFAULT_DEPTH,
    parameter int unsigned almost_full_level = depth - 2
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [data_width-1:0]           wr_data,
    input  logic                            wr,
    output logic                            wr_ready,
    output logic                            wr_almost_full,
    output logic [data_width-1:0]           rd_data,
    output logic                            rd,
    input  logic                            rd_ready,
    output logic [level_width(depth)-1:0]   level,
    input  logic                            stats_clr,
    output logic                            overflow,
    output logic [level_width(depth)-1:0]   max_level
);

    localparam int unsigned AW = $clog2(depth);
    localparam int unsigned PW = ptr_width(depth);
    localparam int unsigned LW = level_width(depth);

    logic [data_width-1:0] mem_q [depth];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          wr_ready_q, wr_ready_d;
    logic          rd_q, rd_d;
    logic          almost_q, almost_d;
    logic          push_s, pop_s;

    assign push_s = wr && wr_ready_q;
    assign pop_s  = rd_q && rd_ready;

    // Flags are computed from the next pointers so every status output can be registered.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        wr_ready_d = wr_ready_q;
        rd_d       = rd_q;
        almost_d   = almost_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        level_d    = LW'(wr_ptr_d - rd_ptr_d);
        wr_ready_d = !((wr_ptr_d[PW-1] != rd_ptr_d[PW-1]) &&
                       (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]));
        rd_d       = (wr_ptr_d != rd_ptr_d);
        almost_d   = (level_d >= LW'(almost_full_level));
    end

    // Pointer and status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            level_q    <= {LW{1'b0}};
            wr_ready_q <= 1'b1;
            rd_q       <= 1'b0;
            almost_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            wr_ready_q <= wr_ready_d;
            rd_q       <= rd_d;
            almost_q   <= almost_d;
        end
    end

    // Storage is deliberately left unreset; stale words are never presented with rd=1.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data        = mem_q[rd_ptr_q[AW-1:0]];
    assign rd             = rd_q;
    assign wr_ready       = wr_ready_q;
    assign wr_almost_full = almost_q;
    assign level          = level_q;

`ifdef SYNC_HANDSHAKE_FIFO_STATS_EN
    sync_handshake_fifo_stats #(
        .depth        (depth)
    ) u_stats (
        .clk_i        (clk),
        .rst_n_i      (reset_n),
        .stats_clr_i  (stats_clr),
        .wr_i         (wr),
        .wr_ready_i   (wr_ready_q),
        .level_i      (level_q),
        .level_next_i (level_d),
        .overflow_o   (overflow),
        .max_level_o  (max_level)
    );
`else
    logic stats_unused_s;
    assign stats_unused_s = stats_clr;
    assign overflow       = 1'b0;
    assign max_level      = {LW{1'b0}};
`endif

endmodule

// File: tb/tb_sync_handshake_fifo.sv
// Self-checking bench: queue-based reference model, directed scenarios, then random traffic.
module tb_sync_handshake_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AFL   = 3;
    localparam int LW    = 3;

    logic          clk;
    logic          reset_n;
    logic [DW-1:0] wr_data;
    logic          wr;
    logic          wr_ready;
    logic          wr_almost_full;
    logic [DW-1:0] rd_data;
    logic          rd;
    logic          rd_ready;
    logic [LW-1:0] level;
    logic          stats_clr;
    logic          overflow;
    logic [LW-1:0] max_level;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] mq[$];
    bit            m_ovf;
    int            m_max;
    bit            cmp_en;

`ifdef SYNC_HANDSHAKE_FIFO_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    sync_handshake_fifo #(
        .data_width        (DW),
        .depth             (DEPTH),
        .almost_full_level (AFL)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .wr_data        (wr_data),
        .wr             (wr),
        .wr_ready       (wr_ready),
        .wr_almost_full (wr_almost_full),
        .rd_data        (rd_data),
        .rd             (rd),
        .rd_ready       (rd_ready),
        .level          (level),
        .stats_clr      (stats_clr),
        .overflow       (overflow),
        .max_level      (max_level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue updated from the handshake rules.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            m_ovf = 1'b0;
            m_max = 0;
        end else begin
            int  old_n;
            bit  full, do_push, do_pop;
            old_n   = mq.size();
            full    = (old_n == DEPTH);
            do_push = wr && !full;
            do_pop  = rd_ready && (old_n != 0);
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(wr_data);
            if (stats_clr) begin
                m_ovf = 1'b0;
                m_max = old_n;
            end else begin
                if (wr && full) m_ovf = 1'b1;
                if (mq.size() > m_max) m_max = mq.size();
            end
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (reset_n && cmp_en) begin
            chk("level", level, mq.size());
            chk("rd", rd, mq.size() != 0);
            chk("wr_ready", wr_ready, mq.size() != DEPTH);
            chk("wr_almost_full", wr_almost_full, mq.size() >= AFL);
            if (mq.size() != 0) chk("rd_data", rd_data, mq[0]);
            chk("overflow", overflow, STATS ? m_ovf : 1'b0);
            chk("max_level", max_level, STATS ? m_max : 0);
        end
    end

    task automatic drive(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
        wr        = w;
        wr_data   = d;
        rd_ready  = r;
        stats_clr = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        wr        = 1'b0;
        wr_data   = '0;
        rd_ready  = 1'b0;
        stats_clr = 1'b0;
        cmp_en    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_level", level, 0);
        chk("reset_rd", rd, 0);
        chk("reset_wr_ready", wr_ready, 1);
        chk("reset_almost", wr_almost_full, 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_max_level", max_level, 0);
        #3 reset_n = 1'b1;
        cmp_en = 1'b1;

        // Single write: one-cycle write-to-read latency.
        drive(1'b1, 8'h11, 1'b0, 1'b0);
        chk("first_rd", rd, 1);
        chk("first_rd_data", rd_data, 8'h11);
        chk("first_level", level, 1);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("first_pop_level", level, 0);

        // Fill to full, then an attempted fifth write.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
            if (i == 2) begin
                chk("af_at3", wr_almost_full, 1);
                chk("ready_at3", wr_ready, 1);
            end
        end
        chk("full_ready", wr_ready, 0);
        chk("full_level", level, 4);
        drive(1'b1, 8'hFF, 1'b0, 1'b0);
        chk("drop_level", level, 4);
        chk("drop_head", rd_data, 8'hA0);
        chk("drop_overflow", overflow, STATS ? 1 : 0);
        chk("drop_max_level", max_level, STATS ? 4 : 0);

        // Pop from full with a concurrent write: write refused.
        drive(1'b1, 8'hBB, 1'b1, 1'b0);
        chk("popfull_level", level, 3);
        chk("popfull_head", rd_data, 8'hA1);
        chk("popfull_ready", wr_ready, 1);
        drive(1'b1, 8'hCC, 1'b0, 1'b0);
        chk("after_write_level", level, 4);
        repeat (4) drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drained_level", level, 0);

        // Statistics clear at level 1.
        drive(1'b1, 8'h01, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_overflow", overflow, 0);
        chk("clr_max_level", max_level, STATS ? 1 : 0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);

        // Back-to-back streaming at constant level 1.
        drive(1'b1, 8'h00, 1'b0, 1'b0);
        for (int i = 1; i < 10; i++) begin
            drive(1'b1, 8'(i), 1'b1, 1'b0);
            chk("stream_level", level, 1);
            chk("stream_data", rd_data, i);
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("stream_end_level", level, 0);

        // Asynchronous reset mid-transfer.
        drive(1'b1, 8'h31, 1'b0, 1'b0);
        drive(1'b1, 8'h32, 1'b0, 1'b0);
        chk("prereset_level", level, 2);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rd", rd, 0);
        chk("async_level", level, 0);
        chk("async_ready", wr_ready, 1);
        #2 reset_n = 1'b1;
        drive(1'b1, 8'h5A, 1'b0, 1'b0);
        chk("postreset_rd", rd, 1);
        chk("postreset_data", rd_data, 8'h5A);
        chk("postreset_level", level, 1);
        drive(1'b0, 8'h00, 1'b1, 1'b0);

        // Randomized traffic alternating between fill-biased and drain-biased phases.
        for (int i = 0; i < 3000; i++) begin
            bit fill;
            fill = ((i / 150) % 2) == 0;
            drive(fill ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                  8'($urandom),
                  fill ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 39) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
